rec_seq_generator: RTL

// - Parametrised linear-recurrence sequence source. Generalises the fixed 3-deep x[n]=x[n-2]+x[n-3] generator.
// - Adds: configurable width, history depth and tap mask; runtime seed loading; valid/ready output; overflow tracking.
// - Feeds sequence/test-pattern consumers that may apply backpressure.

---
 rtl/rec_seq_generator_if.sv | 15 +
 rtl/rec_seq_generator.sv | 90 +++++++++
 2 files changed

// File: rtl/rec_seq_generator_if.sv
// rec_seq_generator_if: seed-load and sample-output handshakes of rec_seq_generator.
interface rec_seq_generator_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             seq_valid;
    logic             seq_ready;
    logic [WIDTH-1:0] seq;
    logic [IDX_W-1:0] seq_idx;
    modport master (input load_valid, load_data, seq_ready, output load_ready, seq_valid, seq, seq_idx);
    modport slave (output load_valid, load_data, seq_ready, input load_ready, seq_valid, seq, seq_idx);
endinterface

// File: rtl/rec_seq_generator.sv
// rec_seq_generator: parametrised linear-recurrence source with seed loading and valid/ready output.
// Define SEQ_GEN_SATURATE_EN to clamp overflowing terms to all-ones instead of wrapping.
module rec_seq_generator #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEPTH-1:0] cfg_taps_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             ovf_o,
    output logic             busy_o,
    rec_seq_generator_if.master bus
);
    localparam int SUM_W = WIDTH + $clog2(DEPTH);
    typedef enum logic {IDLE, RUN} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] h_q [DEPTH];
    logic [WIDTH-1:0] h_d [DEPTH];
    logic [DEPTH-1:0] taps_q, taps_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum;
    logic             wrap;
    logic [WIDTH-1:0] nxt;
    logic             shift;
    logic [WIDTH-1:0] shift_in;
    always_comb begin
        sum = '0;
        for (int i = 0; i < DEPTH; i++)
            sum = sum + (taps_q[i] ? SUM_W'(h_q[i]) : SUM_W'(0));
        wrap = |sum[SUM_W-1:WIDTH];
`ifdef SEQ_GEN_SATURATE_EN
        nxt = wrap ? '1 : sum[WIDTH-1:0];
`else
        nxt = sum[WIDTH-1:0];
`endif
    end
    // Loading a seed and emitting a sample are the same window shift, differing only in the new word.
    always_comb begin
        shift    = (state_q == IDLE) ? bus.load_valid : bus.seq_ready;
        shift_in = (state_q == IDLE) ? bus.load_data : nxt;
        state_d  = state_q;
        h_d      = h_q;
        taps_d   = taps_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        if (shift) begin
            for (int i = 0; i < DEPTH - 1; i++) h_d[i] = h_q[i+1];
            h_d[DEPTH-1] = shift_in;
        end
        if (state_q == IDLE) begin
            if (start_i) begin
                taps_d  = cfg_taps_i;
                idx_d   = '0;
                ovf_d   = 1'b0;
                state_d = RUN;
            end
        end else begin
            if (bus.seq_ready) begin
                idx_d = idx_q + IDX_W'(1);
                ovf_d = ovf_q | wrap;
            end
            if (stop_i) state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++) h_q[i] <= (i == DEPTH - 1) ? WIDTH'(1) : '0;
            taps_q  <= DEPTH'(3);
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            taps_q  <= taps_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.load_ready = (state_q == IDLE);
    assign bus.seq_valid  = (state_q == RUN);
    assign bus.seq        = h_q[0];
    assign bus.seq_idx    = idx_q;
    assign busy_o         = (state_q == RUN);
    assign ovf_o          = ovf_q;
endmodule
